mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DM_WORDS, default 1024, the number of 32-bit data-memory words, word-addressed by addr[11:2].
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low; state clears while reset=0.
REQ-004 SHALL have port instr_M  input  32  instruction held in the M stage.
REQ-005 SHALL have port pc_M  input  32  PC of the M-stage instruction.
REQ-006 SHALL have port alu_M  input  32  ALU result, which is also the memory byte address.
REQ-007 SHALL have port wd_M  input  32  store data, already forwarded from rt.
REQ-008 SHALL have port a3_M  input  5  destination register number.
REQ-009 SHALL have ports MemWrite, RegWrite, Mem2Reg  input  1/1/2  M-stage controls, with Mem2Reg encoded 00=ALU, 01=memory, 10=PC+8.
REQ-010 SHALL have ports instr_W, pc8_W, alu_W, dm_W  output  32 each  registered W-stage copies, with pc8_W = pc_M+8.
REQ-011 SHALL have ports a3_W, RegWrite_W, Mem2Reg_W  output  5/1/2  registered W-stage controls.
REQ-012 SHALL have port dm_err  output  1  sticky flag for an illegal store attempt.

Function
REQ-013 SHALL read the memory combinationally at index alu_M[11:2] (rd_data).
REQ-014 SHALL write wd_M to word alu_M[11:2] on the rising clk edge when MemWrite=1, alu_M[1:0]=00 and alu_M < 4*DM_WORDS.
REQ-015 SHALL, when MemWrite=1 and the address is misaligned (alu_M[1:0]!=00) or alu_M >= 4*DM_WORDS, suppress the write and set dm_err=1 on that edge.
REQ-016 SHALL hold dm_err at 1 until reset; no other event clears it.
REQ-017 SHALL, in simulation, print "@%h: *%h <= %h" with pc_M, alu_M and wd_M on every performed write and print nothing for a suppressed one.
REQ-018 SHALL force rd_data to 0 when alu_M >= 4*DM_WORDS.
REQ-019 SHALL register every W-stage output on each rising edge with no stall and no enable, giving exactly 1-cycle latency from the M-stage inputs.
REQ-020 SHALL register the pre-write memory contents into dm_W when a store and a read address coincide in the same cycle.
REQ-021 SHALL, for a store at cycle N followed by a load of the same address at cycle N+1, give the load the new data (forwarding is not needed).
REQ-022 SHALL compute pc8_W with 32-bit wrap-around and no overflow detection, so 0xFFFFFFFC gives 0x00000004.
REQ-023 SHALL pass RegWrite, Mem2Reg and a3_M through unchanged, except that a3_M=0 forces RegWrite_W=0.
REQ-024 SHALL contain no FSM beyond the pipeline register, the memory array and the dm_err flag.

Reset
REQ-025 SHALL, while reset=0 and regardless of clk, drive all registered outputs to 0 and dm_err to 0.
REQ-026 SHALL clear every memory word to 0x00000000 when reset is asserted.
REQ-027 SHALL, when reset is asserted mid-store, not perform the write and not print it.
REQ-028 SHALL, after reset is released, update state at the first rising edge only.
REQ-029 SHALL ignore a MemWrite that is asserted during reset.

Verification
REQ-030 SHALL be verified by: store then load, where sw with alu_M=0x10, wd_M=0xDEADBEEF, pc_M=0x3000 and then lw at 0x10 -> log line "@00003000: *00000010 <= deadbeef"; next cycle dm_W=0xDEADBEEF, Mem2Reg_W=01.
REQ-031 SHALL be verified by: misaligned store, where sw with alu_M=0x12 -> memory unchanged, no log line, dm_err=1 and still 1 five cycles later.
REQ-032 SHALL be verified by: out-of-range access, where lw with alu_M=0x1000 -> dm_W=0; sw to 0x1000 -> dm_err=1 and word 0 unchanged.
REQ-033 SHALL be verified by: jal pass-through, where pc_M=0x3008, Mem2Reg=10, a3_M=31, RegWrite=1 -> pc8_W=0x3010, a3_W=31, RegWrite_W=1 one cycle later.
REQ-034 SHALL be verified by: a $zero destination, where RegWrite=1 with a3_M=0 -> RegWrite_W=0.
REQ-035 SHALL be verified by: asynchronous reset mid-operation, where reset goes low between edges during a sw to 0x20 -> all outputs 0 immediately; after release a lw at 0x20 gives dm_W=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// ============================================================================
// Module      : mem_stage_if
// Description : M-stage to W-stage bundle for the memory pipeline stage.
//               master : upstream side, drives M-stage fields and observes
//                        the W-stage copies and the store error flag.
//               slave  : mem_stage itself.
// Ports       : instr_M, pc_M, alu_M, wd_M, a3_M, MemWrite, RegWrite, Mem2Reg
//               (M stage in); instr_W, pc8_W, alu_W, dm_W, a3_W, RegWrite_W,
//               Mem2Reg_W, dm_err (W stage out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic [31:0] instr_M;
  logic [31:0] pc_M;
  logic [31:0] alu_M;
  logic [31:0] wd_M;
  logic [4:0]  a3_M;
  logic        MemWrite;
  logic        RegWrite;
  logic [1:0]  Mem2Reg;

  logic [31:0] instr_W;
  logic [31:0] pc8_W;
  logic [31:0] alu_W;
  logic [31:0] dm_W;
  logic [4:0]  a3_W;
  logic        RegWrite_W;
  logic [1:0]  Mem2Reg_W;
  logic        dm_err;

  modport master (
    output instr_M, pc_M, alu_M, wd_M, a3_M, MemWrite, RegWrite, Mem2Reg,
    input  instr_W, pc8_W, alu_W, dm_W, a3_W, RegWrite_W, Mem2Reg_W, dm_err
  );

  modport slave (
    input  instr_M, pc_M, alu_M, wd_M, a3_M, MemWrite, RegWrite, Mem2Reg,
    output instr_W, pc8_W, alu_W, dm_W, a3_W, RegWrite_W, Mem2Reg_W, dm_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Memory pipeline stage. Word-addressed data memory with a
//               combinational read and a clocked, checked store, followed by
//               the M->W pipeline register. Illegal stores (misaligned or out
//               of range) are dropped and raise a sticky error flag.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset (clears memory too)
//               bus   - mem_stage_if.slave (M-stage inputs, W-stage outputs)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DM_WORDS = 1024
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_if.slave     bus
);

  localparam int          c_AW         = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  // One bit wider than the address so 4*DM_WORDS never truncates.
  localparam logic [32:0] c_ADDR_LIMIT = 33'(4 * DM_WORDS);

  logic [31:0]     mem_q [DM_WORDS];
  logic            dm_err_q;

  logic [31:0]     instr_q, pc8_q, alu_q, dm_q;
  logic [4:0]      a3_q;
  logic            regwrite_q;
  logic [1:0]      mem2reg_q;

  logic [31:0]     pc8_d;
  logic            regwrite_d;

  logic [c_AW-1:0] w_idx;
  logic            w_in_range;
  logic            w_aligned;
  logic            w_store_ok;
  logic            w_store_bad;
  logic [31:0]     w_rd_data;

  assign w_idx       = bus.alu_M[c_AW+1:2];
  assign w_in_range  = {1'b0, bus.alu_M} < c_ADDR_LIMIT;
  assign w_aligned   = (bus.alu_M[1:0] == 2'b00);
  assign w_store_ok  = bus.MemWrite & w_aligned & w_in_range;
  assign w_store_bad = bus.MemWrite & ~(w_aligned & w_in_range);

  // Out-of-range reads return zero instead of an aliased word.
  assign w_rd_data   = w_in_range ? mem_q[w_idx] : 32'h0000_0000;

  assign pc8_d       = bus.pc_M + 32'd8;
  // Writes to $zero are never committed.
  assign regwrite_d  = bus.RegWrite & (bus.a3_M != 5'd0);

  // Data memory; the read above samples the pre-write value at the edge, so
  // a same-cycle store/load pair sees old data and the next cycle sees new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (w_store_ok) begin
      mem_q[w_idx] <= bus.wd_M;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", bus.pc_M, bus.alu_M, bus.wd_M);
`endif
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dm_err_q <= 1'b0;
    end else if (w_store_bad) begin
      dm_err_q <= 1'b1;
    end
  end

  // M->W pipeline register: free-running, no stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= 32'h0000_0000;
      pc8_q      <= 32'h0000_0000;
      alu_q      <= 32'h0000_0000;
      dm_q       <= 32'h0000_0000;
      a3_q       <= 5'd0;
      regwrite_q <= 1'b0;
      mem2reg_q  <= 2'b00;
    end else begin
      instr_q    <= bus.instr_M;
      pc8_q      <= pc8_d;
      alu_q      <= bus.alu_M;
      dm_q       <= w_rd_data;
      a3_q       <= bus.a3_M;
      regwrite_q <= regwrite_d;
      mem2reg_q  <= bus.Mem2Reg;
    end
  end

  assign bus.instr_W    = instr_q;
  assign bus.pc8_W      = pc8_q;
  assign bus.alu_W      = alu_q;
  assign bus.dm_W       = dm_q;
  assign bus.a3_W       = a3_q;
  assign bus.RegWrite_W = regwrite_q;
  assign bus.Mem2Reg_W  = mem2reg_q;
  assign bus.dm_err     = dm_err_q;

endmodule

`default_nettype wire
